// File: rtl/cacheline_adaptor.sv
// Bridges the cache's wide line port to a narrow burst memory port: writebacks are
// serialised into beats, fills are assembled from beats, and each ends with a resp_o pulse.
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    localparam int unsigned Beats = LINE_W / BURST_W;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] buf_q, buf_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              last_beat;

    assign last_beat = (cnt_q == LastBeat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
        end
    end

    // Writeback takes priority; the cache reissues a pending fill after the writeback completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (write_i) begin
                    state_d = StWrite;
                end else if (read_i) begin
                    state_d = StRead;
                end
            end
            StRead, StWrite: begin
                if (resp_i && last_beat) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        buf_d  = buf_q;
        line_d = line_q;
        unique case (state_q)
            StIdle: begin
                if (write_i || read_i) begin
                    addr_d = {address_i[31:5], 5'b0};
                end
                if (write_i) begin
                    buf_d = line_i;
                end
            end
            StRead: begin
                if (resp_i) begin
                    for (int b = 0; b < Beats; b++) begin
                        if (cnt_q == CntW'(b)) begin
                            line_d[b*BURST_W +: BURST_W] = burst_i;
                        end
                    end
                    // Counter only returns to zero through StDone.
                    cnt_d = last_beat ? cnt_q : cnt_q + CntW'(1);
                end
            end
            StWrite: begin
                if (resp_i) begin
                    cnt_d = last_beat ? cnt_q : cnt_q + CntW'(1);
                end
            end
            StDone:  cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        read_o  = (state_q == StRead);
        write_o = (state_q == StWrite);
        resp_o  = (state_q == StDone);
        burst_o = '0;
        for (int b = 0; b < Beats; b++) begin
            if (cnt_q == CntW'(b)) begin
                burst_o = buf_q[b*BURST_W +: BURST_W];
            end
        end
    end

    assign line_o    = line_q;
    assign address_o = addr_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized cache/memory traffic.
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cacheline_adaptor #(
        .LINE_W (256),
        .BURST_W(64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, tracked as a kind plus beats moved so far.
    int          m_op;     // 0 none, 1 fill, 2 writeback
    int          m_beats;
    bit          m_resp;
    logic [31:0] m_addr;
    logic [63:0] m_line [4];
    logic [63:0] m_buf  [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op = 0; m_beats = 0; m_resp = 0; m_addr = '0;
            for (int i = 0; i < 4; i++) begin
                m_line[i] = '0;
                m_buf[i]  = '0;
            end
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_op == 0) begin
            if (write_i || read_i) m_addr = address_i & 32'hFFFF_FFE0;
            if (write_i) begin
                m_op = 2; m_beats = 0;
                for (int i = 0; i < 4; i++) m_buf[i] = line_i[64*i +: 64];
            end else if (read_i) begin
                m_op = 1; m_beats = 0;
            end
        end else if (resp_i) begin
            if (m_op == 1) m_line[m_beats] = burst_i;
            m_beats++;
            if (m_beats == 4) begin
                m_op = 0;
                m_resp = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_read_o", read_o, m_op == 1);
            check("model_write_o", write_o, m_op == 2);
            check("model_resp_o", resp_o, m_resp);
            check("model_address_o", address_o, m_addr);
            check("model_line_o", line_o, {m_line[3], m_line[2], m_line[1], m_line[0]});
            if (m_op == 2) check("model_burst_o", burst_o, m_buf[m_beats]);
        end
    end

    int n_rd = 0, n_wr = 0, n_resp = 0;
    always @(posedge clk) begin
        if (read_o)  n_rd++;
        if (write_o) n_wr++;
        if (resp_o)  n_resp++;
    end

    // Called on a negedge while the DUT is in the fill state.
    task automatic serve_fill(input logic [255:0] line, input logic [15:0] pat, input int plen);
        int k = 0, p = 0, guard = 0;
        while (k < 4 && guard < 64) begin
            resp_i  = (p < plen) ? pat[p] : 1'b1;
            p++;
            burst_i = line[64*k +: 64];
            @(negedge clk);
            if (resp_i) k++;
            guard++;
        end
        check("fill_guard", guard < 64, 1);
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        check("fill_resp", resp_o, 1);
    endtask

    task automatic serve_write(input logic [255:0] line, input logic [15:0] pat, input int plen);
        int k = 0, p = 0, guard = 0;
        while (k < 4 && guard < 64) begin
            resp_i = (p < plen) ? pat[p] : 1'b1;
            p++;
            if (resp_i) check("wb_burst", burst_o, line[64*k +: 64]);
            @(negedge clk);
            if (resp_i) k++;
            guard++;
        end
        check("wb_guard", guard < 64, 1);
        resp_i = 1'b0;
        check("wb_resp", resp_o, 1);
    endtask

    localparam logic [255:0] FillLine = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WbLine   = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [255:0] AltLine  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                         64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_1234_8765};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rd, base_wr, base_resp;
        bit req_act;
        int r;

        #2 rst_n = 1'b0;
        #1;
        check("rst_read_o", read_o, 0);
        check("rst_write_o", write_o, 0);
        check("rst_resp_o", resp_o, 0);
        check("rst_line_o", line_o, 0);
        check("rst_burst_o", burst_o, 0);
        check("rst_address_o", address_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill with resp_i held high.
        base_rd = n_rd; base_resp = n_resp;
        read_i = 1'b1; address_i = 32'h0000_1234;
        @(negedge clk);
        check("fill_address_o", address_o, 32'h0000_1220);
        serve_fill(FillLine, 16'h0000, 0);
        read_i = 1'b0;
        check("fill_line_o", line_o, FillLine);
        @(negedge clk);
        check("fill_read_cycles", n_rd - base_rd, 4);
        check("fill_resp_pulses", n_resp - base_resp, 1);
        check("fill_line_hold", line_o, FillLine);

        // Writeback with resp_i held high.
        base_wr = n_wr; base_resp = n_resp;
        write_i = 1'b1; line_i = WbLine; address_i = 32'h0000_0100;
        @(negedge clk);
        serve_write(WbLine, 16'h0000, 0);
        write_i = 1'b0;
        @(negedge clk);
        check("wb_write_cycles", n_wr - base_wr, 4);
        check("wb_resp_pulses", n_resp - base_resp, 1);

        // Fill with stalled beats: resp_i = 1,0,0,1,1,0,1.
        base_rd = n_rd; base_resp = n_resp;
        read_i = 1'b1; address_i = 32'h0000_2000;
        @(negedge clk);
        serve_fill(AltLine, 16'h0059, 7);
        read_i = 1'b0;
        check("stall_line_o", line_o, AltLine);
        @(negedge clk);
        check("stall_read_cycles", n_rd - base_rd, 7);
        check("stall_resp_pulses", n_resp - base_resp, 1);

        // Simultaneous read and write: writeback first, then the held read.
        base_rd = n_rd;
        read_i = 1'b1; write_i = 1'b1; line_i = AltLine; address_i = 32'h0000_3000;
        @(negedge clk);
        check("both_write_o", write_o, 1);
        check("both_read_o", read_o, 0);
        serve_write(AltLine, 16'h0000, 0);
        write_i = 1'b0;
        check("both_no_read", n_rd - base_rd, 0);
        @(negedge clk);
        check("both_idle_gap", read_o, 0);
        @(negedge clk);
        check("both_read_starts", read_o, 1);
        serve_fill(WbLine, 16'h0000, 0);
        read_i = 1'b0;
        check("both_line_o", line_o, WbLine);
        @(negedge clk);

        // Reset in the middle of a fill.
        read_i = 1'b1; address_i = 32'h0000_0040;
        @(negedge clk);
        resp_i = 1'b1;
        burst_i = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        burst_i = 64'hDEAD_BEEF_0000_0002;
        @(negedge clk);
        resp_i = 1'b0; read_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_read_o", read_o, 0);
        check("mid_rst_resp_o", resp_o, 0);
        check("mid_rst_address_o", address_o, 0);
        check("mid_rst_line_o", line_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_resp_o", resp_o, 0);
        read_i = 1'b1; address_i = 32'h0000_0060;
        @(negedge clk);
        serve_fill(FillLine, 16'h0000, 0);
        read_i = 1'b0;
        check("post_rst_line_o", line_o, FillLine);
        @(negedge clk);

        // Back-to-back writeback then fill.
        base_resp = n_resp;
        write_i = 1'b1; line_i = WbLine; address_i = 32'h0000_0500;
        @(negedge clk);
        serve_write(WbLine, 16'h0000, 0);
        write_i = 1'b0;
        read_i = 1'b1; address_i = 32'h0000_00E0;
        @(negedge clk);
        check("b2b_gap", read_o, 0);
        @(negedge clk);
        check("b2b_read_o", read_o, 1);
        check("b2b_address_o", address_o, 32'h0000_00E0);
        serve_fill(AltLine, 16'h0000, 0);
        read_i = 1'b0;
        @(negedge clk);
        check("b2b_resp_pulses", n_resp - base_resp, 2);

        // Randomized traffic.
        req_act = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            resp_i  = ($urandom_range(0, 99) < 60);
            burst_i = {$urandom, $urandom};
            if (!req_act) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 9);
                    write_i   = (r < 4) || (r == 9);
                    read_i    = (r >= 4);
                    address_i = $urandom;
                    for (int w = 0; w < 8; w++) line_i[32*w +: 32] = $urandom;
                    req_act = 1'b1;
                end
            end else if (resp_o) begin
                read_i  = 1'b0;
                write_i = 1'b0;
                req_act = 1'b0;
            end
        end
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
